// File: rtl/pulse_train_gen_pkg.sv
// Shared types and defaults for the pulse train generator.
package pulse_train_gen_pkg;
  localparam int PTG_CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;
endpackage

// File: rtl/pulse_train_cnt.sv
// Loadable down-counter; a zero load value is clamped to 1 so it never wraps.
// o_expired marks the last cycle of the loaded interval (count == 1).
module pulse_train_cnt
  import pulse_train_gen_pkg::*;
#(
  parameter int CNT_W = PTG_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_val,
  input  logic             i_dec,
  output logic             o_expired
);
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                      r_cnt <= '0;
    else if (i_load)               r_cnt <= (i_val == '0) ? CNT_W'(1) : i_val;
    else if (i_dec && r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
  end

  assign o_expired = (r_cnt == CNT_W'(1));
endmodule

// File: rtl/pulse_train_gen.sv
// Programmable pulse train: N pulses of H high / L low cycles, start/busy/done handshake.
// Optional `abort` input when PULSE_TRAIN_GEN_ABORT_EN is defined.
module pulse_train_gen
  import pulse_train_gen_pkg::*;
#(
  parameter int CNT_W = PTG_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
`ifdef PULSE_TRAIN_GEN_ABORT_EN
  input  logic             abort,
`endif
  input  logic             start,
  input  logic [CNT_W-1:0] high_cycles,
  input  logic [CNT_W-1:0] low_cycles,
  input  logic [CNT_W-1:0] num_pulses,
  output logic             signal_out,
  output logic             busy,
  output logic             done
);
  state_t           r_state;
  logic [CNT_W-1:0] r_high, r_low;
  logic             r_sig, r_busy, r_done;

  logic             w_abort;
  logic             w_ph_load, w_ph_dec, w_ph_exp;
  logic [CNT_W-1:0] w_ph_val;
  logic             w_pl_load, w_pl_dec, w_pl_exp;

`ifdef PULSE_TRAIN_GEN_ABORT_EN
  assign w_abort = abort && (r_state != ST_IDLE);
`else
  assign w_abort = 1'b0;
`endif

  always_comb begin
    w_ph_load = 1'b0;
    w_ph_dec  = 1'b0;
    w_ph_val  = r_high;
    w_pl_load = 1'b0;
    w_pl_dec  = 1'b0;
    if (!w_abort) begin
      case (r_state)
        ST_IDLE: if (start && num_pulses != '0) begin
          w_ph_load = 1'b1;
          w_ph_val  = high_cycles;
          w_pl_load = 1'b1;
        end
        ST_HIGH: if (w_ph_exp) begin
          if (!w_pl_exp) begin
            w_ph_load = 1'b1;
            w_ph_val  = r_low;
            w_pl_dec  = 1'b1;
          end
        end else w_ph_dec = 1'b1;
        ST_LOW: if (w_ph_exp) w_ph_load = 1'b1;
                else          w_ph_dec  = 1'b1;
        default: ;
      endcase
    end
  end

  pulse_train_cnt #(.CNT_W(CNT_W)) u_phase (
    .clk(clk), .rst(rst), .i_load(w_ph_load), .i_val(w_ph_val),
    .i_dec(w_ph_dec), .o_expired(w_ph_exp)
  );

  pulse_train_cnt #(.CNT_W(CNT_W)) u_pulses (
    .clk(clk), .rst(rst), .i_load(w_pl_load), .i_val(num_pulses),
    .i_dec(w_pl_dec), .o_expired(w_pl_exp)
  );

  // Outputs are registered alongside the state so they always match it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_high  <= '0;
      r_low   <= '0;
      r_sig   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_abort) begin
        r_state <= ST_IDLE;
        r_sig   <= 1'b0;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: if (start) begin
            r_high <= high_cycles;
            r_low  <= low_cycles;
            if (num_pulses != '0) begin
              r_state <= ST_HIGH;
              r_sig   <= 1'b1;
              r_busy  <= 1'b1;
            end else r_done <= 1'b1;
          end
          ST_HIGH: if (w_ph_exp) begin
            r_sig <= 1'b0;
            if (w_pl_exp) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else r_state <= ST_LOW;
          end
          ST_LOW: if (w_ph_exp) begin
            r_state <= ST_HIGH;
            r_sig   <= 1'b1;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign signal_out = r_sig;
  assign busy       = r_busy;
  assign done       = r_done;
endmodule

// File: tb/tb_pulse_train_gen.sv
// Bench for pulse_train_gen: vector table, hand sequences, random run against a timing model.
module tb_pulse_train_gen;
  logic       clk = 1'b0;
  logic       rst;
  logic       start, start4;
  logic [7:0] high_cycles, low_cycles, num_pulses;
  logic [3:0] high4, low4, num4;
  logic       signal_out, busy, done;
  logic       sig4, busy4, done4;
`ifdef PULSE_TRAIN_GEN_ABORT_EN
  logic       abort, abort4;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pulse_train_gen #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst),
`ifdef PULSE_TRAIN_GEN_ABORT_EN
    .abort(abort),
`endif
    .start(start), .high_cycles(high_cycles), .low_cycles(low_cycles),
    .num_pulses(num_pulses), .signal_out(signal_out), .busy(busy), .done(done)
  );

  pulse_train_gen #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst),
`ifdef PULSE_TRAIN_GEN_ABORT_EN
    .abort(abort4),
`endif
    .start(start4), .high_cycles(high4), .low_cycles(low4),
    .num_pulses(num4), .signal_out(sig4), .busy(busy4), .done(done4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compare len cycles; bit i of each mask is the value expected i+1 cycles after accept.
  task automatic check_seq(input string name, input int len,
                           input logic [31:0] e_sig, input logic [31:0] e_busy,
                           input logic [31:0] e_done);
    for (int i = 0; i < len; i++) begin
      if (i > 0) step();
      chk($sformatf("%s_sig_c%0d", name, i + 1), 32'(signal_out), 32'(e_sig[i]));
      chk($sformatf("%s_busy_c%0d", name, i + 1), 32'(busy), 32'(e_busy[i]));
      chk($sformatf("%s_done_c%0d", name, i + 1), 32'(done), 32'(e_done[i]));
    end
  endtask

  task automatic run_train(input logic [7:0] h, input logic [7:0] l, input logic [7:0] n,
                           output int busy_n, output int edges, output int done_at);
    logic prev;
    high_cycles = h; low_cycles = l; num_pulses = n; start = 1'b1;
    step();
    start = 1'b0;
    busy_n = 0; edges = 0; done_at = -1; prev = 1'b0;
    for (int c = 1; c <= 1000; c++) begin
      if (busy) busy_n++;
      if (signal_out && !prev) edges++;
      prev = signal_out;
      if (done) begin
        done_at = c;
        break;
      end
      step();
    end
  endtask

  // Reference model: outputs as a function of cycles since accept.
  bit m_run;
  int m_k, m_h, m_l, m_n;

  function automatic int m_total(int h, int l, int n);
    return (n == 0) ? 0 : n * h + (n - 1) * l;
  endfunction

  function automatic logic [2:0] model_out();
    int tot = m_total(m_h, m_l, m_n);
    if (!m_run) return 3'b000;
    if (m_k >= 1 && m_k <= tot) return {((m_k - 1) % (m_h + m_l)) < m_h, 1'b1, 1'b0};
    if (m_k == tot + 1) return 3'b001;
    return 3'b000;
  endfunction

  task automatic model_step(input bit st, input bit ab);
    bit idle = !m_run || (m_k > m_total(m_h, m_l, m_n));
    if (ab && !idle) m_run = 1'b0;
    else if (idle && st) begin
      m_h = (high_cycles == 0) ? 1 : int'(high_cycles);
      m_l = (low_cycles == 0) ? 1 : int'(low_cycles);
      m_n = int'(num_pulses);
      m_k = 0;
      m_run = 1'b1;
    end
    if (m_run && m_k < 100000) m_k++;
  endtask

  typedef struct {
    logic [7:0] h, l, n;
    int busy_n, edges, done_at;
  } vec_t;

  initial begin
    vec_t tbl[9];
    int bn, ed, da, dcnt, bcnt4, ecnt4, dat4;
    logic p4;
    bit ab;
    logic [2:0] exp3;

    tbl[0] = '{8'd2,   8'd3,   8'd3,   12,  3,   13};
    tbl[1] = '{8'd0,   8'd0,   8'd2,   3,   2,   4};
    tbl[2] = '{8'd0,   8'd5,   8'd0,   0,   0,   1};
    tbl[3] = '{8'd1,   8'd1,   8'd1,   1,   1,   2};
    tbl[4] = '{8'd4,   8'd1,   8'd2,   9,   2,   10};
    tbl[5] = '{8'd3,   8'd0,   8'd3,   11,  3,   12};
    tbl[6] = '{8'd255, 8'd7,   8'd1,   255, 1,   256};
    tbl[7] = '{8'd1,   8'd255, 8'd2,   257, 2,   258};
    tbl[8] = '{8'd1,   8'd1,   8'd255, 509, 255, 510};

    rst = 1'b0; start = 1'b0; start4 = 1'b0;
    high_cycles = 8'd0; low_cycles = 8'd0; num_pulses = 8'd0;
    high4 = 4'd0; low4 = 4'd0; num4 = 4'd0;
`ifdef PULSE_TRAIN_GEN_ABORT_EN
    abort = 1'b0; abort4 = 1'b0;
`endif
    #22;
    chk("reset_sig", 32'(signal_out), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_busy4", 32'(busy4), 0);
    @(negedge clk) rst = 1'b1;
    step();

    for (int i = 0; i < 9; i++) begin
      run_train(tbl[i].h, tbl[i].l, tbl[i].n, bn, ed, da);
      chk($sformatf("tbl%0d_busy_cycles", i), bn, tbl[i].busy_n);
      chk($sformatf("tbl%0d_edges", i), ed, tbl[i].edges);
      chk($sformatf("tbl%0d_done_at", i), da, tbl[i].done_at);
    end
    step();

    // Basic train waveform
    high_cycles = 8'd2; low_cycles = 8'd3; num_pulses = 8'd3; start = 1'b1;
    step(); start = 1'b0;
    check_seq("basic", 13, 32'b0110001100011, 32'b0111111111111, 32'b1000000000000);
    step();

    // Zero lengths: H=0, L=0, N=2
    high_cycles = 8'd0; low_cycles = 8'd0; num_pulses = 8'd2; start = 1'b1;
    step(); start = 1'b0;
    check_seq("zero_hl", 4, 32'b0101, 32'b0111, 32'b1000);
    step();

    // Start held high: one train while busy, back-to-back trains with a single low gap
    high_cycles = 8'd2; low_cycles = 8'd1; num_pulses = 8'd2; start = 1'b1;
    step();
    check_seq("start_held", 12, 32'b011011011011, 32'b011111011111, 32'b100000100000);
    start = 1'b0;
    step(); step();

    // Inputs changed right after accept must not affect the train
    high_cycles = 8'd3; low_cycles = 8'd2; num_pulses = 8'd2; start = 1'b1;
    step(); start = 1'b0;
    high_cycles = 8'd1; low_cycles = 8'd7; num_pulses = 8'd9;
    check_seq("latched", 9, 32'b011100111, 32'b011111111, 32'b100000000);
    step();

    // Asynchronous reset during HIGH of pulse 2
    high_cycles = 8'd3; low_cycles = 8'd2; num_pulses = 8'd3; start = 1'b1;
    step(); start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("rst_mid_pre_sig", 32'(signal_out), 1);
    #1 rst = 1'b0;
    #1;
    chk("rst_mid_sig", 32'(signal_out), 0);
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_done", 32'(done), 0);
    @(negedge clk) rst = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (done || busy) dcnt++;
    end
    chk("rst_mid_no_done", dcnt, 0);
    run_train(8'd3, 8'd2, 8'd3, bn, ed, da);
    chk("rst_after_busy", bn, 13);
    chk("rst_after_edges", ed, 3);
    chk("rst_after_done_at", da, 14);
    step();

    // Counter limits on the 4-bit instance
    high4 = 4'd15; low4 = 4'd15; num4 = 4'd15; start4 = 1'b1;
    step(); start4 = 1'b0;
    bcnt4 = 0; ecnt4 = 0; dat4 = -1; p4 = 1'b0;
    for (int c = 1; c <= 1000; c++) begin
      if (busy4) bcnt4++;
      if (sig4 && !p4) ecnt4++;
      p4 = sig4;
      if (done4) begin
        dat4 = c;
        break;
      end
      step();
    end
    chk("limit_busy", bcnt4, 435);
    chk("limit_edges", ecnt4, 15);
    chk("limit_done_at", dat4, 436);
    step();

`ifdef PULSE_TRAIN_GEN_ABORT_EN
    high_cycles = 8'd2; low_cycles = 8'd3; num_pulses = 8'd3; start = 1'b1;
    step(); start = 1'b0;
    step(); step();
    chk("abort_in_low_busy", 32'(busy), 1);
    abort = 1'b1;
    step(); abort = 1'b0;
    chk("abort_sig", 32'(signal_out), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    dcnt = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done || signal_out) dcnt++;
    end
    chk("abort_no_done", dcnt, 0);
    high_cycles = 8'd1; low_cycles = 8'd1; num_pulses = 8'd1;
    abort = 1'b1; start = 1'b1;
    step(); abort = 1'b0; start = 1'b0;
    chk("abort_idle_start_sig", 32'(signal_out), 1);
    chk("abort_idle_start_busy", 32'(busy), 1);
    step();
    chk("abort_idle_start_done", 32'(done), 1);
    step();
`endif

    // Random run against the model, starting from a fresh reset
    #1 rst = 1'b0;
    m_run = 1'b0; m_k = 0; m_h = 1; m_l = 1; m_n = 0;
    @(negedge clk) rst = 1'b1;
    step();
    for (int i = 0; i < 3000; i++) begin
      high_cycles = 8'($urandom_range(0, 3));
      low_cycles  = 8'($urandom_range(0, 3));
      num_pulses  = 8'($urandom_range(0, 3));
      start       = ($urandom_range(0, 3) == 0);
      ab          = 1'b0;
`ifdef PULSE_TRAIN_GEN_ABORT_EN
      ab          = ($urandom_range(0, 15) == 0);
      abort       = ab;
`endif
      model_step(start, ab);
      step();
      exp3 = model_out();
      chk($sformatf("rand%0d_sig_busy_done", i), {29'd0, signal_out, busy, done}, {29'd0, exp3});
    end
    start = 1'b0;
`ifdef PULSE_TRAIN_GEN_ABORT_EN
    abort = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pulse_train_gen.md
# pulse_train_gen

- Generates a programmable train of positive pulses on a single-bit output: N pulses, each H cycles high followed by L cycles low.
- Serves as the stimulus and drive source for edge-detection logic such as `pos_edge_detector`: every pulse produces exactly one rising edge on `signal_out`.
- A start/busy/done handshake lets a controller or testbench launch a train and learn when it has finished.

## Interface
- `CNT_W`, 8, width of the high-length, low-length and pulse-count fields and of the internal counters.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  launch request; sampled only in IDLE.
- `high_cycles`  in  CNT_W  high-phase length; 0 is treated as 1.
- `low_cycles`  in  CNT_W  low-phase length between pulses; 0 is treated as 1.
- `num_pulses`  in  CNT_W  number of pulses; 0 produces no pulse.
- `signal_out`  out  1  generated pulse train, registered.
- `busy`  out  1  high while a train is in progress.
- `done`  out  1  one-cycle completion strobe.

## Operation
- States:
  - IDLE: `signal_out`=0, `busy`=0.
  - HIGH: `signal_out`=1, `busy`=1.
  - LOW: `signal_out`=0, `busy`=1.
- Reset (`rst`=0, asynchronous, at any time, including mid-train):
  - `state`=IDLE, `signal_out`=0, `busy`=0, `done`=0, all counters cleared.
  - No `done` is issued for an interrupted train.
- IDLE with `start`=1:
  - Latch `high_cycles`, `low_cycles` and `num_pulses` into internal registers.
  - Input changes after the accept have no effect on the running train.
  - If the latched count ≥1: go to HIGH with phase counter = max(H,1) and pulse counter = N.
  - If the latched count = 0: stay in IDLE and pulse `done` on the next cycle; `signal_out` never rises.
- HIGH:
  - Decrement the phase counter each cycle.
  - When it expires, decrement the pulse counter.
  - If pulses remain: go to LOW with phase counter = max(L,1).
  - If no pulses remain: go to IDLE and assert `done` for one cycle.
- LOW: decrement the phase counter each cycle; when it expires, go to HIGH with phase counter = max(H,1).
- `start` is ignored while `busy`=1. There is no queueing.
- Arithmetic:
  - All counters are unsigned CNT_W-bit down-counters.
  - Counters never wrap: a 0 length is clamped to 1 at load time.
  - Maximum values are 2^CNT_W−1 cycles per phase and 2^CNT_W−1 pulses.

## Timing
- `start` accepted at edge t; then:
  - Cycles t+1 … t+H: `signal_out`=1.
  - Cycles t+H+1 … t+H+L: `signal_out`=0 (only if N>1).
  - The pattern repeats with period H+L.
- The final high phase ends at cycle t+(N−1)(H+L)+H.
- At the next cycle:
  - `done`=1 for exactly 1 cycle.
  - `busy`=0 and `signal_out`=0 in the same cycle.
  - There is no trailing low phase.
- `busy` rises at t+1 and stays high continuously until `done`.
- A `start` asserted during the `done` cycle is accepted, because the FSM is already in IDLE. `signal_out` then rises on the following cycle, giving a minimum of 1 low cycle between trains.
- `num_pulses`=0: `done`=1 at t+1; `busy` stays 0.
- All outputs are registered. No combinational path exists from inputs to outputs.

## Configuration
- Macro: `PULSE_TRAIN_GEN_ABORT_EN`.
- Defined:
  - Adds input port `abort` (1 bit).
  - `abort`=1 while `busy`=1 forces IDLE on the next edge: `signal_out`=0, `busy`=0, `done`=0 (no strobe).
  - `abort` in IDLE has no effect.
  - `abort` has priority over `start` in the same cycle.
- Undefined: the port does not exist, and a train always runs to completion unless reset.

## Structure
- Shared package `pulse_train_gen_pkg` holds:
  - The state enum (IDLE, HIGH, LOW).
  - The default `CNT_W` constant.
- One sub-module: `pulse_train_cnt`.
  - A loadable CNT_W down-counter with a 0→1 clamp on load and an `expired` flag.
  - Instantiated twice: once for the phase counter, once for the pulse counter.
- The FSM and output registers live in the top level.

## Test plan
- Reset mid-train:
  - Stimulus: `rst` low during HIGH of pulse 2 of an N=3 train.
  - Required: `signal_out`, `busy` and `done` all 0 immediately; no `done` after release; the next `start` runs a full train.
- Basic train:
  - Stimulus: H=2, L=3, N=3.
  - Required: `signal_out` reads 1,1,0,0,0,1,1,0,0,0,1,1 from t+1; `done`=1 at t+13; `busy` high for t+1…t+12.
  - A `pos_edge_detector` fed by `signal_out` produces exactly 3 `edge_out` pulses.
- Zero handling:
  - Stimulus (a): N=0.
  - Required (a): `done` at t+1; `signal_out` stays 0.
  - Stimulus (b): H=0, L=0, N=2.
  - Required (b): `signal_out` reads 1,0,1 then `done`.
- Start collisions:
  - Stimulus: `start` held high for the whole train; also `start` during the `done` cycle.
  - Required: exactly one train while busy; back-to-back trains separated by exactly 1 low cycle.
- Input stability:
  - Stimulus: change `high_cycles` mid-train.
  - Required: pulse widths follow the latched value.
- Counter limits:
  - Stimulus: CNT_W=4, H=15, L=15, N=15.
  - Required: total busy time of 15·30−15 = 435 cycles; no wrap.
- Abort (with `PULSE_TRAIN_GEN_ABORT_EN`):
  - Stimulus: `abort` asserted during LOW.
  - Required: IDLE on the next cycle, no `done`.
  - Stimulus: `abort` and `start` together in IDLE.
  - Required: the train starts.
